pipeline_hazard_controller: RTL and testbench

- Issue scheduler for the 4-stage microcoded pipeline (s0 decode/operand read, s1 ALU/mem request, s2 mem/branch, s3 writeback).
- Tracks the destination register and memory use of every instruction in flight in s1–s3.
- Stalls s0 on RAW dependencies flagged by the s0 microcode dep-check bits, and on a branch flush kills s1 and the s0 candidate.
- Arbitrates the shared memory port between instruction fetch and s1 data access, and keeps a saturating stall-cycle counter.

---
 rtl/pipeline_hazard_controller.sv | 96 +++++++++
 tb/tb_pipeline_hazard_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Issue scheduler for the 4-stage pipeline: RAW stall detection, branch-flush kill,
// memory-port arbitration between fetch and s1 data access, saturating stall counter.
module pipeline_hazard_controller #(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0_valid,
  input  logic [4:0]       s0_rs1,
  input  logic [4:0]       s0_rs2,
  input  logic [4:0]       s0_rd,
  input  logic             s0_check_rs1_dep,
  input  logic             s0_check_rs2_dep,
  input  logic             s0_reg_write_enable,
  input  logic             s0_mem_in_use,
  input  logic             flush,
  output logic             s0_stall,
  output logic             s0_issue,
  output logic             s1_bubble,
  output logic             fetch_enable,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] rd;
    logic       mem;
  } entry_t;

  localparam entry_t EMPTY = '0;

  entry_t           e1_q, e1_d;
  entry_t           e2_q, e2_d;
  entry_t           e3_q, e3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             mem_busy;
  logic             unused_e3;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic writes(input entry_t e, input logic [4:0] r);
    return e.v & e.we & (e.rd == r);
  endfunction

  // x0 is hardwired, so writers of rd=0 never create a dependency
  function automatic logic reg_match(input logic [4:0] r, input entry_t a,
                                     input entry_t b, input entry_t c);
    return (r != 5'd0) & (writes(a, r) | writes(b, r) | (!WB_BYPASS & writes(c, r)));
  endfunction

  always_comb begin
    hazard   = s0_valid &
               ((s0_check_rs1_dep & reg_match(s0_rs1, e1_q, e2_q, e3_q)) |
                (s0_check_rs2_dep & reg_match(s0_rs2, e1_q, e2_q, e3_q)));
    mem_busy = e1_q.v & e1_q.mem;
  end

  // Issue is also held off while in reset; stall falls naturally as entries clear
  assign s0_stall     = hazard & ~flush;
  assign s0_issue     = rst_n & s0_valid & ~hazard & ~flush;
  assign fetch_enable = ~mem_busy & (~s0_stall | flush);
  assign s1_bubble    = ~e1_q.v;
  assign stall_count  = cnt_q;
  assign unused_e3    = ^e3_q;

  always_comb begin
    e1_d = EMPTY;
    if (s0_issue) begin
      e1_d = '{v: 1'b1, we: s0_reg_write_enable, rd: s0_rd, mem: s0_mem_in_use};
    end
    // The branch sits in s2 and proceeds; only the younger s1 slot is killed
    e2_d  = flush ? EMPTY : e1_q;
    e3_d  = e2_q;
    cnt_d = s0_stall ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_q  <= EMPTY;
      e2_q  <= EMPTY;
      e3_q  <= EMPTY;
      cnt_q <= '0;
    end else begin
      e1_q  <= e1_d;
      e2_q  <= e2_d;
      e3_q  <= e3_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two configurations driven in lockstep and
// compared against an in-flight instruction list model (age-based).
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       s0_valid, s0_check_rs1_dep, s0_check_rs2_dep;
  logic       s0_reg_write_enable, s0_mem_in_use, flush;
  logic [4:0] s0_rs1, s0_rs2, s0_rd;

  logic        st_a, is_a, bb_a, fe_a;
  logic [3:0]  cnt_a;
  logic        st_b, is_b, bb_b, fe_b;
  logic [31:0] cnt_b;

  pipeline_hazard_controller #(.WB_BYPASS(1'b1), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .s0_valid(s0_valid), .s0_rs1(s0_rs1), .s0_rs2(s0_rs2),
    .s0_rd(s0_rd), .s0_check_rs1_dep(s0_check_rs1_dep), .s0_check_rs2_dep(s0_check_rs2_dep),
    .s0_reg_write_enable(s0_reg_write_enable), .s0_mem_in_use(s0_mem_in_use), .flush(flush),
    .s0_stall(st_a), .s0_issue(is_a), .s1_bubble(bb_a), .fetch_enable(fe_a),
    .stall_count(cnt_a));

  pipeline_hazard_controller #(.WB_BYPASS(1'b0), .CNT_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .s0_valid(s0_valid), .s0_rs1(s0_rs1), .s0_rs2(s0_rs2),
    .s0_rd(s0_rd), .s0_check_rs1_dep(s0_check_rs1_dep), .s0_check_rs2_dep(s0_check_rs2_dep),
    .s0_reg_write_enable(s0_reg_write_enable), .s0_mem_in_use(s0_mem_in_use), .flush(flush),
    .s0_stall(st_b), .s0_issue(is_b), .s1_bubble(bb_b), .fetch_enable(fe_b),
    .stall_count(cnt_b));

  int checks   = 0;
  int failures = 0;

  // Model: list of issued instructions with their age (1 = in s1, 2 = s2, 3 = s3)
  typedef struct {
    bit       we;
    bit [4:0] rd;
    bit       mem;
    int       age;
  } instr_t;
  typedef instr_t iq_t[$];

  iq_t    qa, qb;
  longint cnt_ma, cnt_mb;

  // lim = oldest age that still blocks a reader (2 with write-through, 3 without)
  function automatic bit f_match(iq_t q, int lim, logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].we && q[i].rd == r && q[i].age <= lim) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit f_haz(iq_t q, int lim);
    return s0_valid && ((s0_check_rs1_dep && f_match(q, lim, s0_rs1)) ||
                        (s0_check_rs2_dep && f_match(q, lim, s0_rs2)));
  endfunction

  function automatic bit f_busy(iq_t q);
    foreach (q[i]) if (q[i].age == 1 && q[i].mem) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit f_occ(iq_t q);
    foreach (q[i]) if (q[i].age == 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic iq_t f_next(iq_t q, bit fl, bit iss);
    iq_t    r;
    instr_t e;
    foreach (q[i]) begin
      if (!(fl && q[i].age == 1)) begin
        e     = q[i];
        e.age = e.age + 1;
        if (e.age <= 3) r.push_back(e);
      end
    end
    if (iss) begin
      e.we  = s0_reg_write_enable;
      e.rd  = s0_rd;
      e.mem = s0_mem_in_use;
      e.age = 1;
      r.push_back(e);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit ha, hb, sa, sb;
    ha = f_haz(qa, 2);
    hb = f_haz(qb, 3);
    sa = ha && !flush;
    sb = hb && !flush;
    chk("a_stall", 32'(st_a), 32'(sa));
    chk("a_issue", 32'(is_a), 32'(rst_n && s0_valid && !ha && !flush));
    chk("a_fetch", 32'(fe_a), 32'(!f_busy(qa) && (!sa || flush)));
    chk("a_bubble", 32'(bb_a), 32'(!f_occ(qa)));
    chk("a_count", 32'(cnt_a), 32'(cnt_ma));
    chk("b_stall", 32'(st_b), 32'(sb));
    chk("b_issue", 32'(is_b), 32'(rst_n && s0_valid && !hb && !flush));
    chk("b_fetch", 32'(fe_b), 32'(!f_busy(qb) && (!sb || flush)));
    chk("b_bubble", 32'(bb_b), 32'(!f_occ(qb)));
    chk("b_count", cnt_b, 32'(cnt_mb));
  endtask

  // Called just after a rising edge with inputs already applied
  task automatic tick();
    bit ha, hb;
    #2;
    check_all();
    @(posedge clk);
    if (rst_n) begin
      ha = f_haz(qa, 2);
      hb = f_haz(qb, 3);
      if (ha && !flush && cnt_ma != 15) cnt_ma++;
      if (hb && !flush && cnt_mb != 64'hFFFF_FFFF) cnt_mb++;
      qa = f_next(qa, flush, s0_valid && !ha && !flush);
      qb = f_next(qb, flush, s0_valid && !hb && !flush);
    end
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic c1, input logic c2,
                        input logic we, input logic mem, input logic fl);
    s0_valid            = v;
    s0_rs1              = rs1;
    s0_rs2              = rs2;
    s0_rd               = rd;
    s0_check_rs1_dep    = c1;
    s0_check_rs2_dep    = c2;
    s0_reg_write_enable = we;
    s0_mem_in_use       = mem;
    flush               = fl;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    bit found;
    cnt_ma = 0;
    cnt_mb = 0;
    rst_n  = 1'b0;
    set_in(1, 5, 5, 5, 1, 1, 1, 1, 0);
    #3;
    check_all();
    chk("rst_issue_a", 32'(is_a), 32'd0);
    chk("rst_fetch_a", 32'(fe_a), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Producer immediately ahead: 2 stalls with write-through, 3 without
    set_in(1, 0, 0, 5, 0, 0, 1, 0, 0);
    tick();
    set_in(1, 5, 0, 8, 1, 0, 0, 0, 0);
    repeat (5) tick();
    idle(4);
    chk("a_cnt_dep1", 32'(cnt_a), 32'd2);
    chk("b_cnt_dep1", cnt_b, 32'd3);

    // x0 writer and cleared dep bit never stall
    set_in(1, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    set_in(1, 0, 0, 1, 1, 0, 0, 0, 0); tick();
    set_in(1, 0, 0, 7, 0, 0, 1, 0, 0); tick();
    set_in(1, 0, 7, 1, 0, 0, 0, 0, 0); tick();
    idle(4);
    chk("a_cnt_gate", 32'(cnt_a), 32'd2);
    chk("b_cnt_gate", cnt_b, 32'd3);

    // Producer three ahead: only the no-write-through variant stalls, once
    set_in(1, 0, 0, 9, 0, 0, 1, 0, 0); tick();
    idle(2);
    set_in(1, 9, 0, 1, 1, 0, 0, 0, 0); tick(); tick();
    idle(4);
    chk("a_cnt_dep3", 32'(cnt_a), 32'd2);
    chk("b_cnt_dep3", cnt_b, 32'd4);

    // Flush kills the load in s1 and the s0 candidate; the hazard on it vanishes
    set_in(1, 0, 0, 3, 0, 0, 1, 1, 0); tick();
    set_in(1, 1, 0, 2, 1, 0, 1, 0, 1);
    #2;
    chk("flush_issue_a", 32'(is_a), 32'd0);
    chk("flush_fetch_a", 32'(fe_a), 32'd0);
    tick();
    set_in(1, 3, 0, 1, 1, 0, 0, 0, 0);
    #2;
    chk("flush_bubble_a", 32'(bb_a), 32'd1);
    chk("flush_nohaz_b", 32'(st_b), 32'd0);
    tick();
    idle(4);

    // Store blocks fetch for one cycle; a stall on that cycle keeps it blocked
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("mem_fetch_blk", 32'(fe_a), 32'd0);
    tick();
    tick();
    set_in(1, 0, 0, 4, 0, 0, 1, 1, 0); tick();
    set_in(1, 4, 0, 0, 1, 0, 0, 0, 0);
    #2;
    chk("mem_stall_st", 32'(st_a), 32'd1);
    chk("mem_stall_fe", 32'(fe_a), 32'd0);
    tick(); tick(); tick();
    idle(4);

    // Self-dependent writer keeps stalling: 4-bit counter saturates at 15
    set_in(1, 10, 0, 10, 1, 0, 1, 0, 0);
    repeat (30) tick();
    chk("a_cnt_sat", 32'(cnt_a), 32'd15);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (f_haz(qa, 2)) found = 1'b1;
      else tick();
    end
    chk("stall_found", 32'(found), 32'd1);
    #2;
    chk("pre_rst_stall", 32'(st_a), 32'(f_haz(qa, 2)));
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    cnt_ma = 0;
    cnt_mb = 0;
    #1;
    chk("rst_mid_cnt", 32'(cnt_a), 32'd0);
    chk("rst_mid_bub", 32'(bb_a), 32'd1);
    chk("rst_mid_stall", 32'(st_a), 32'd0);
    chk("rst_mid_issue", 32'(is_a), 32'd0);
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic over a small register window to provoke frequent dependencies
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 7) == 0));
      tick();
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
